// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-subset core (DP, LDR/STR, B) sharing one memory
// port between fetch and data access, sequenced by an internal phase FSM.
module mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       flags,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_fetch  = 3'd1,
        st_decode = 3'd2,
        st_exec   = 3'd3,
        st_mem    = 3'd4,
        st_memwb  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      ir;
    logic [WIDTH-1:0] rf [16];
    logic [WIDTH-1:0] a_q, b_q, imm_q, aluout, dr;

    logic [3:0] cond, cmd, rn, rd, rm, bsel;
    logic [1:0] op;
    logic       imm_sel, set_flags, is_load, up;

    assign cond      = ir[31:28];
    assign op        = ir[27:26];
    assign imm_sel   = ir[25];
    assign cmd       = ir[24:21];
    assign up        = ir[23];
    assign set_flags = ir[20];
    assign is_load   = ir[20];
    assign rn        = ir[19:16];
    assign rd        = ir[15:12];
    assign rm        = ir[3:0];

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v, r;
        {n, z, cf, v} = nzcv;
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cf;
            4'h3:    r = !cf;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cf && !z;
            4'h9:    r = !cf || z;
            4'ha:    r = (n == v);
            4'hb:    r = (n != v);
            4'hc:    r = !z && (n == v);
            4'hd:    r = z || (n != v);
            4'he:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // imm8 rotated right by twice the rot4 field, always within 32 bits
    function automatic logic [31:0] rot_imm(input logic [11:0] f);
        logic [31:0] x;
        logic [5:0]  sh;
        x  = {24'b0, f[7:0]};
        sh = {1'b0, f[11:8], 1'b0};
        return (x >> sh) | (x << (6'd32 - sh));
    endfunction

    logic [WIDTH-1:0]        pc_plus4, rn_val, b_val, br_target;
    logic signed [25:0]      br_off26;
    logic signed [WIDTH-1:0] br_off;

    // R15 reads as instruction address + 8; pc already points 4 past it
    always_comb begin
        pc_plus4  = pc + WIDTH'(4);
        bsel      = (op == 2'b01) ? rd : rm;
        rn_val    = (rn == 4'hf) ? pc_plus4 : rf[rn];
        b_val     = (bsel == 4'hf) ? pc_plus4 : rf[bsel];
        br_off26  = signed'({ir[23:0], 2'b00});
        br_off    = WIDTH'(br_off26);
        br_target = pc_plus4 + $unsigned(br_off);
    end

    logic [WIDTH-1:0] srcb, bop, alu_res;
    logic [WIDTH:0]   sum;
    logic [3:0]       alu_nzcv;
    logic             dp_ok, is_sub;

    always_comb begin
        is_sub  = (cmd == 4'b0010);
        srcb    = imm_sel ? imm_q : b_q;
        bop     = is_sub ? ~srcb : srcb;
        sum     = {1'b0, a_q} + {1'b0, bop} + {{WIDTH{1'b0}}, is_sub};
        alu_res = sum[WIDTH-1:0];
        dp_ok   = 1'b1;
        case (cmd)
            4'b0000:          alu_res = a_q & srcb;
            4'b1100:          alu_res = a_q | srcb;
            4'b0100, 4'b0010: ;
            default:          dp_ok = 1'b0;
        endcase
        alu_nzcv = {alu_res[WIDTH-1], alu_res == '0, 2'b00};
        if (cmd == 4'b0100 || is_sub) begin
            alu_nzcv[1] = sum[WIDTH];
            alu_nzcv[0] = (a_q[WIDTH-1] == bop[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= st_idle;
        else        state_q <= state_d;
    end

    // mem_req is decoded from state so an async reset drops it immediately
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = aluout;
        case (state_q)
            st_idle:   state_d = st_fetch;
            st_fetch: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_d = st_decode;
            end
            st_decode: state_d = cond_pass(cond, flags) ? st_exec : st_fetch;
            st_exec:   state_d = (op == 2'b01) ? st_mem : st_fetch;
            st_mem: begin
                mem_req = 1'b1;
                mem_we  = !is_load;
                if (mem_ready) state_d = is_load ? st_memwb : st_fetch;
            end
            st_memwb:  state_d = st_fetch;
            default:   state_d = st_idle;
        endcase
    end

    assign mem_wdata = b_q;
    assign state     = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            flags  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            aluout <= '0;
            dr     <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (state_q)
                st_fetch: if (mem_ready) begin
                    ir <= mem_rdata[31:0];
                    pc <= pc_plus4;
                end
                st_decode: begin
                    a_q   <= rn_val;
                    b_q   <= b_val;
                    imm_q <= (op == 2'b01) ? WIDTH'(ir[11:0]) : WIDTH'(rot_imm(ir[11:0]));
                end
                st_exec: begin
                    if (op == 2'b00 && dp_ok) begin
                        if (rd == 4'hf) pc <= alu_res;
                        else            rf[rd] <= alu_res;
                        if (set_flags) flags <= alu_nzcv;
                    end
                    if (op == 2'b01) aluout <= up ? a_q + imm_q : a_q - imm_q;
                    if (op == 2'b10) pc <= br_target;
                end
                st_mem: if (mem_ready && is_load) dr <= mem_rdata;
                st_memwb: begin
                    if (rd == 4'hf) pc <= dr;
                    else            rf[rd] <= dr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: directed programs in a word memory; every memory
// transaction is checked against a queue of hand-derived expected transactions.
module tb_mc_datapath;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  flags;
    logic [2:0]  state;

    logic [31:0] mem [64];
    logic [31:0] cyc;
    logic        mon_en;
    int          checks, errors;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cyc;
    } txn_t;

    txn_t exp_q[$];

    mc_datapath #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .flags(flags), .state(state)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] c);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.cyc = c;
        exp_q.push_back(t);
    endtask

    task automatic monitor();
        txn_t e;
        forever begin
            @(negedge clk);
            if (mon_en && reset && mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txn_unexpected: got addr 0x%08h we %0b at cyc %0d, expected none",
                             mem_addr, mem_we, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_cyc", cyc, e.cyc);
                    check("txn_we", 32'(mem_we), 32'(e.we));
                    check("txn_addr", mem_addr, e.addr);
                    if (e.we) check("txn_wdata", mem_wdata, e.wdata);
                end
            end
        end
    endtask

    task automatic wait_cyc(input logic [31:0] n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic run_start();
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_state", 32'(state), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        mon_en = 1'b0; mem_ready = 1'b1;
        reset = 1'b1;
        clear_mem();
        fork monitor(); join_none
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_flags", 32'(flags), 32'd0);

        // Program A: NOP, ADD, STR, LDR, STR, SUBS, STR, loop
        mem[0] = 32'hE1A00000; mem[1] = 32'hE2801005; mem[2] = 32'hE5801010;
        mem[3] = 32'hE5903020; mem[4] = 32'hE5803030; mem[5] = 32'hE0512001;
        mem[6] = 32'hE5802034; mem[7] = 32'hEAFFFFFE; mem[8] = 32'hDEADBEEF;
        exp_txn(0, 32'h00, 0, 1);  exp_txn(0, 32'h04, 0, 4);  exp_txn(0, 32'h08, 0, 7);
        exp_txn(1, 32'h10, 32'd5, 10);
        exp_txn(0, 32'h0C, 0, 11); exp_txn(0, 32'h20, 0, 14); exp_txn(0, 32'h10, 0, 16);
        exp_txn(1, 32'h30, 32'hDEADBEEF, 19);
        exp_txn(0, 32'h14, 0, 20); exp_txn(0, 32'h18, 0, 23);
        exp_txn(1, 32'h34, 32'h0, 26);
        exp_txn(0, 32'h1C, 0, 27);
        run_start();
        drain(200);
        check("a_flags_subs", 32'(flags), 32'b0110);
        do_reset();

        // Program B: SUBS, ADD, BEQ taken, NE skip, STR, ORRS, ADDS, STR, loop
        clear_mem();
        mem[0] = 32'hE0512001; mem[1] = 32'hE2801005; mem[2] = 32'h0A000001;
        mem[3] = 32'hE2811001; mem[4] = 32'hE2811001; mem[5] = 32'h12811007;
        mem[6] = 32'hE5801010; mem[7] = 32'hE3904102; mem[8] = 32'hE0945004;
        mem[9] = 32'hE5804014; mem[10] = 32'hEAFFFFFE;
        exp_txn(0, 32'h00, 0, 1);  exp_txn(0, 32'h04, 0, 4);  exp_txn(0, 32'h08, 0, 7);
        exp_txn(0, 32'h14, 0, 10); exp_txn(0, 32'h18, 0, 12);
        exp_txn(1, 32'h10, 32'd5, 15);
        exp_txn(0, 32'h1C, 0, 16); exp_txn(0, 32'h20, 0, 19); exp_txn(0, 32'h24, 0, 22);
        exp_txn(1, 32'h14, 32'h80000000, 25);
        exp_txn(0, 32'h28, 0, 26);
        run_start();
        wait_cyc(19);
        @(negedge clk);
        check("b_flags_orrs", 32'(flags), 32'b1000);
        drain(200);
        check("b_flags_adds", 32'(flags), 32'b0111);
        do_reset();

        // Program C: wait states on a fetch and on a store
        clear_mem();
        mem[0] = 32'hE2801005; mem[1] = 32'hE5801010; mem[2] = 32'hEAFFFFFE;
        exp_txn(0, 32'h00, 0, 4); exp_txn(0, 32'h04, 0, 7);
        exp_txn(1, 32'h10, 32'd5, 12);
        exp_txn(0, 32'h08, 0, 13);
        mem_ready = 1'b0;
        run_start();
        for (int k = 1; k <= 3; k++) begin
            wait_cyc(32'(k));
            @(negedge clk);
            check("c_fetch_req", 32'(mem_req), 32'd1);
            check("c_fetch_addr", mem_addr, 32'h0);
            check("c_fetch_pc", pc, 32'h0);
        end
        wait_cyc(4);
        mem_ready = 1'b1;
        wait_cyc(5);
        check("c_pc_after", pc, 32'h4);
        wait_cyc(10);
        mem_ready = 1'b0;
        for (int k = 10; k <= 11; k++) begin
            wait_cyc(32'(k));
            @(negedge clk);
            check("c_str_addr", mem_addr, 32'h10);
            check("c_str_we", 32'(mem_we), 32'd1);
            check("c_str_wdata", mem_wdata, 32'd5);
        end
        wait_cyc(12);
        mem_ready = 1'b1;
        drain(200);
        do_reset();

        // Program D: reset pulsed during a stalled store
        clear_mem();
        mem[0] = 32'hE2801005; mem[1] = 32'hE5801010; mem[2] = 32'hEAFFFFFE;
        exp_txn(0, 32'h00, 0, 1); exp_txn(0, 32'h04, 0, 4);
        run_start();
        wait_cyc(7);
        mem_ready = 1'b0;
        @(negedge clk);
        check("d_mem_req", 32'(mem_req), 32'd1);
        check("d_mem_we", 32'(mem_we), 32'd1);
        check("d_mem_addr", mem_addr, 32'h10);
        #2 reset = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        mon_en = 1'b0;
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        clear_mem();
        mem[0] = 32'hE5801010; mem[1] = 32'hEAFFFFFE;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_pc", pc, 32'h0);
        check("abort_state", 32'(state), 32'd0);
        exp_txn(0, 32'h00, 0, 1);
        exp_txn(1, 32'h10, 32'h0, 4);
        exp_txn(0, 32'h04, 0, 5);
        run_start();
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
